// File: rtl/sky130_sram_port0_ctrl.sv
// Port-0 (RW) requester for the sky130 1rw1r SRAM macro: valid/ready requests in,
// in-order read responses out, optional post-reset zero-fill of the array.
module sky130_sram_port0_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned NUM_WMASKS = 1,
    parameter int unsigned RSP_DEPTH  = 4,
    parameter bit          INIT_EN    = 1'b1
) (
    input  logic                  clk0,
    input  logic                  rstb0,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    localparam int unsigned PW = $clog2(RSP_DEPTH);
    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic                  init_done_q, init_done_d;
    logic                  csb0_q, csb0_d;
    logic                  web0_q, web0_d;
    logic [NUM_WMASKS-1:0] wmask0_q, wmask0_d;
    logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
    logic [DATA_WIDTH-1:0] din0_q, din0_d;
    logic                  rd_v1_q, rd_v1_d;
    logic                  rd_v2_q, rd_v2_d;
    logic [PW:0]           wr_ptr_q, wr_ptr_d;
    logic [PW:0]           rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];

    logic [CW-1:0]         fifo_count;
    logic [CW:0]           credit_used;
    logic                  accept;
    logic                  push;
    logic                  pop;

    // Pointers carry a lap bit so full and empty stay distinct for any depth.
    function automatic logic [PW:0] ptr_inc(input logic [PW:0] p);
        if (p[PW-1:0] == PW'(RSP_DEPTH - 1))
            return {~p[PW], {PW{1'b0}}};
        else
            return p + 1'b1;
    endfunction

    always_comb begin
        if (wr_ptr_q[PW] == rd_ptr_q[PW])
            fifo_count = CW'(wr_ptr_q[PW-1:0]) - CW'(rd_ptr_q[PW-1:0]);
        else
            fifo_count = CW'(RSP_DEPTH) - CW'(rd_ptr_q[PW-1:0]) + CW'(wr_ptr_q[PW-1:0]);
    end

    assign credit_used = (CW+1)'(rd_v1_q) + (CW+1)'(rd_v2_q) + (CW+1)'(fifo_count);
    assign req_ready   = init_done_q && (state_q == ST_RUN) && (credit_used < (CW+1)'(RSP_DEPTH));
    assign accept      = req_valid && req_ready;
    // Read sampled by the macro one edge after accept; dout0 is only stable at the edge after that.
    assign push        = rd_v2_q;
    assign rsp_valid   = (fifo_count != '0);
    assign pop         = rsp_valid && rsp_ready;
    assign rsp_rdata   = rsp_valid ? fifo_q[rd_ptr_q[PW-1:0]] : '0;

    assign init_done = init_done_q;
    assign csb0      = csb0_q;
    assign web0      = web0_q;
    assign wmask0    = wmask0_q;
    assign addr0     = addr0_q;
    assign din0      = din0_q;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        csb0_d      = 1'b1;
        web0_d      = 1'b1;
        wmask0_d    = wmask0_q;
        addr0_d     = addr0_q;
        din0_d      = din0_q;
        rd_v1_d     = accept && !req_we;
        rd_v2_d     = rd_v1_q;
        wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case (state_q)
            ST_INIT: begin
                csb0_d     = 1'b0;
                web0_d     = 1'b0;
                wmask0_d   = '1;
                din0_d     = '0;
                addr0_d    = init_cnt_q;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == '1) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                init_done_d = 1'b1;
                if (accept) begin
                    csb0_d   = 1'b0;
                    web0_d   = ~req_we;
                    wmask0_d = req_wmask;
                    addr0_d  = req_addr;
                    din0_d   = req_wdata;
                end
            end
        endcase
    end

    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            state_q     <= INIT_EN ? ST_INIT : ST_RUN;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            csb0_q      <= 1'b1;
            web0_q      <= 1'b1;
            wmask0_q    <= '0;
            addr0_q     <= '0;
            din0_q      <= '0;
            rd_v1_q     <= 1'b0;
            rd_v2_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            csb0_q      <= csb0_d;
            web0_q      <= web0_d;
            wmask0_q    <= wmask0_d;
            addr0_q     <= addr0_d;
            din0_q      <= din0_d;
            rd_v1_q     <= rd_v1_d;
            rd_v2_q     <= rd_v2_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk0) begin
        if (push)
            fifo_q[wr_ptr_q[PW-1:0]] <= dout0;
    end

endmodule
